// File: rtl/uart_rx_byte.sv
// uart_rx_byte: oversampled UART receiver. It turns the asynchronous rx line
// into bytes for the LED command decoder.
// Sample timing comes from the enable_clk tick, which runs at OVERSAMPLE x baud.
// The default frame is 8N1, sent LSB first.
// Optional build macro: UART_RX_PARITY_EN. It adds an even-parity bit
// (8E1) and the parity_err output.
//
// state   | meaning
// --------+------------------------------------------------------------
// S_IDLE  | line idle, looking for a high-to-low edge on rx_s every clk
// S_START | counting to mid start bit, rejecting glitches
// S_DATA  | sampling DATA_BITS data bits, one per bit period
// S_PARITY| sampling the parity bit (UART_RX_PARITY_EN only)
// S_STOP  | sampling the stop bit, then pulsing the result
//
// rst_n is active-high despite its name. It is kept that way to match the
// surrounding system.
module uart_rx_byte #(
   parameter int OVERSAMPLE = 16,
   parameter int DATA_BITS  = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       enable_clk,
   input  logic       rx,
   output logic [7:0] data_out,
   output logic       data_valid,
   output logic       frame_err
`ifdef UART_RX_PARITY_EN
   ,
   output logic       parity_err
`endif
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam logic [TW-1:0] T_HALF = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [2:0]    B_LAST = 3'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP
`ifdef UART_RX_PARITY_EN
      ,
      S_PARITY
`endif
   } state_t;

   state_t                 state, state_nx;
   logic                   rx_m, rx_s, rx_prev;
   logic [TW-1:0]          tick_cnt, tick_nx;
   logic [2:0]             bit_cnt, bit_nx;
   logic [DATA_BITS-1:0]   shreg, sh_nx;
   logic [7:0]             dout_nx;
   logic                   dv_nx, fe_nx;
`ifdef UART_RX_PARITY_EN
   logic                   par_q, par_nx, pe_nx;
`endif

   // Two-flop synchroniser plus one delayed copy for falling-edge detection.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         rx_m    <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_m    <= rx;
         rx_s    <= rx_m;
         rx_prev <= rx_s;
      end
   end

   // FSM state, counters, shift register and registered output pulses.
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state      <= S_IDLE;
         tick_cnt   <= '0;
         bit_cnt    <= '0;
         shreg      <= '0;
         data_out   <= 8'h00;
         data_valid <= 1'b0;
         frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q      <= 1'b0;
         parity_err <= 1'b0;
`endif
      end else begin
         state      <= state_nx;
         tick_cnt   <= tick_nx;
         bit_cnt    <= bit_nx;
         shreg      <= sh_nx;
         data_out   <= dout_nx;
         data_valid <= dv_nx;
         frame_err  <= fe_nx;
`ifdef UART_RX_PARITY_EN
         par_q      <= par_nx;
         parity_err <= pe_nx;
`endif
      end
   end

   // Next-state logic. Everything except the IDLE edge detect is tick-gated.
   always_comb begin
      state_nx = state;
      tick_nx  = tick_cnt;
      bit_nx   = bit_cnt;
      sh_nx    = shreg;
      dout_nx  = data_out;
      dv_nx    = 1'b0;
      fe_nx    = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_nx   = par_q;
      pe_nx    = 1'b0;
`endif
      case (state)
         S_IDLE: begin
            if (rx_prev && !rx_s) begin
               state_nx = S_START;
               tick_nx  = '0;
            end
         end
         S_START: begin
            if (enable_clk) begin
               if (tick_cnt == T_HALF) begin
                  if (rx_s) begin
                     state_nx = S_IDLE;
                  end else begin
                     state_nx = S_DATA;
                     tick_nx  = '0;
                     bit_nx   = '0;
                  end
               end else begin
                  tick_nx = tick_cnt + TW'(1);
               end
            end
         end
         S_DATA: begin
            if (enable_clk) begin
               if (tick_cnt == T_LAST) begin
                  sh_nx   = {rx_s, shreg[DATA_BITS-1:1]};
                  tick_nx = '0;
                  if (bit_cnt == B_LAST) begin
`ifdef UART_RX_PARITY_EN
                     state_nx = S_PARITY;
`else
                     state_nx = S_STOP;
`endif
                  end else begin
                     bit_nx = bit_cnt + 3'd1;
                  end
               end else begin
                  tick_nx = tick_cnt + TW'(1);
               end
            end
         end
`ifdef UART_RX_PARITY_EN
         S_PARITY: begin
            if (enable_clk) begin
               if (tick_cnt == T_LAST) begin
                  par_nx   = rx_s;
                  tick_nx  = '0;
                  state_nx = S_STOP;
               end else begin
                  tick_nx = tick_cnt + TW'(1);
               end
            end
         end
`endif
         S_STOP: begin
            if (enable_clk) begin
               if (tick_cnt == T_LAST) begin
                  state_nx = S_IDLE;
                  tick_nx  = '0;
                  if (!rx_s) begin
                     fe_nx = 1'b1;
`ifdef UART_RX_PARITY_EN
                  end else if (^{shreg, par_q}) begin
                     pe_nx = 1'b1;
`endif
                  end else begin
                     dv_nx   = 1'b1;
                     dout_nx = 8'(shreg);
                  end
               end else begin
                  tick_nx = tick_cnt + TW'(1);
               end
            end
         end
         default: state_nx = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte. enable_clk is high every clk with
// OVERSAMPLE = 16, so one bit period is 16 clks.
module tb_uart_rx_byte;

   localparam int OS = 16;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       enable_clk;
   logic       rx;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_err;
`ifdef UART_RX_PARITY_EN
   logic       parity_err;
`endif

   int tests = 0;
   int fails = 0;
   int vcnt  = 0;
   int fcnt  = 0;
   int pcnt  = 0;
   int both  = 0;
   logic [7:0] vq[$];

   uart_rx_byte #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .enable_clk (enable_clk),
      .rx         (rx),
      .data_out   (data_out),
      .data_valid (data_valid),
      .frame_err  (frame_err)
`ifdef UART_RX_PARITY_EN
      ,
      .parity_err (parity_err)
`endif
   );

   always #5 clk = ~clk;

   // Pulse monitor, sampled on the falling edge away from DUT updates.
   always @(negedge clk) begin
      if (data_valid) begin
         vcnt = vcnt + 1;
         vq.push_back(data_out);
      end
      if (frame_err) fcnt = fcnt + 1;
      if (data_valid && frame_err) both = both + 1;
`ifdef UART_RX_PARITY_EN
      if (parity_err) pcnt = pcnt + 1;
      if (parity_err && (data_valid || frame_err)) both = both + 1;
`endif
   end

   task automatic clear_mon();
      vcnt = 0;
      fcnt = 0;
      pcnt = 0;
      vq.delete();
   endtask

   task automatic drive_bit(input logic v, input int clks);
      rx = v;
      repeat (clks) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_v);
      drive_bit(1'b0, OS);
      for (int i = 0; i < 8; i++) drive_bit(b[i], OS);
`ifdef UART_RX_PARITY_EN
      drive_bit(^b, OS);
`endif
      drive_bit(stop_v, OS);
   endtask

   task automatic idle(input int clks);
      drive_bit(1'b1, clks);
   endtask

   task automatic test_reset();
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      tests++;
      if (data_out !== 8'h00) begin
         fails++; $display("FAIL reset_data_out: got %h expected 00", data_out);
      end
      tests++;
      if (data_valid !== 1'b0) begin
         fails++; $display("FAIL reset_data_valid: got %b expected 0", data_valid);
      end
      tests++;
      if (frame_err !== 1'b0) begin
         fails++; $display("FAIL reset_frame_err: got %b expected 0", frame_err);
      end
      rst_n = 1'b0;
      idle(2 * OS);
   endtask

   task automatic test_single();
      clear_mon();
      send_frame(8'h6E, 1'b1);
      idle(2 * OS);
      tests++;
      if (vcnt !== 1) begin
         fails++; $display("FAIL single_count: got %0d expected 1", vcnt);
      end
      tests++;
      if (data_out !== 8'h6E) begin
         fails++; $display("FAIL single_data: got %h expected 6e", data_out);
      end
      tests++;
      if (fcnt !== 0) begin
         fails++; $display("FAIL single_frame_err: got %0d expected 0", fcnt);
      end
   endtask

   task automatic test_back_to_back();
      logic [7:0] exp [3];
      exp[0] = 8'h35; exp[1] = 8'hA0; exp[2] = 8'hFF;
      clear_mon();
      for (int i = 0; i < 3; i++) send_frame(exp[i], 1'b1);
      idle(2 * OS);
      tests++;
      if (vcnt !== 3) begin
         fails++; $display("FAIL b2b_count: got %0d expected 3", vcnt);
      end
      for (int i = 0; i < 3; i++) begin
         tests++;
         if (vq.size() <= i) begin
            fails++; $display("FAIL b2b_byte%0d: got none expected %h", i, exp[i]);
         end else if (vq[i] !== exp[i]) begin
            fails++; $display("FAIL b2b_byte%0d: got %h expected %h", i, vq[i], exp[i]);
         end
      end
   endtask

   task automatic test_glitch();
      clear_mon();
      drive_bit(1'b0, 5);
      idle(3 * OS);
      tests++;
      if (vcnt !== 0 || fcnt !== 0) begin
         fails++; $display("FAIL glitch_no_pulse: got valid=%0d ferr=%0d expected 0/0", vcnt, fcnt);
      end
      send_frame(8'h01, 1'b1);
      idle(2 * OS);
      tests++;
      if (vcnt !== 1) begin
         fails++; $display("FAIL glitch_follow_count: got %0d expected 1", vcnt);
      end
      tests++;
      if (data_out !== 8'h01) begin
         fails++; $display("FAIL glitch_follow_data: got %h expected 01", data_out);
      end
   endtask

   task automatic test_frame_err();
      clear_mon();
      send_frame(8'h55, 1'b0);
      idle(2 * OS);
      tests++;
      if (fcnt !== 1) begin
         fails++; $display("FAIL ferr_count: got %0d expected 1", fcnt);
      end
      tests++;
      if (vcnt !== 0) begin
         fails++; $display("FAIL ferr_no_valid: got %0d expected 0", vcnt);
      end
      tests++;
      if (data_out !== 8'h01) begin
         fails++; $display("FAIL ferr_data_hold: got %h expected 01", data_out);
      end
      send_frame(8'h33, 1'b1);
      idle(2 * OS);
      tests++;
      if (data_out !== 8'h33 || vcnt !== 1) begin
         fails++; $display("FAIL ferr_recover: got %h/%0d expected 33/1", data_out, vcnt);
      end
   endtask

   task automatic test_reset_mid();
      logic [7:0] b;
      b = 8'hC3;
      clear_mon();
      drive_bit(1'b0, OS);
      for (int i = 0; i < 4; i++) drive_bit(b[i], OS);
      drive_bit(b[4], OS / 2);
      rst_n = 1'b1;
      #1;
      tests++;
      if (data_out !== 8'h00 || data_valid !== 1'b0 || frame_err !== 1'b0) begin
         fails++; $display("FAIL midreset_outputs: got %h/%b/%b expected 00/0/0",
                           data_out, data_valid, frame_err);
      end
      rx = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      idle(2 * OS);
      tests++;
      if (vcnt !== 0 || fcnt !== 0) begin
         fails++; $display("FAIL midreset_no_pulse: got valid=%0d ferr=%0d expected 0/0", vcnt, fcnt);
      end
      send_frame(8'h7E, 1'b1);
      idle(2 * OS);
      tests++;
      if (data_out !== 8'h7E || vcnt !== 1) begin
         fails++; $display("FAIL midreset_recover: got %h/%0d expected 7e/1", data_out, vcnt);
      end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic send_frame_par(input logic [7:0] b, input logic par_v);
      drive_bit(1'b0, OS);
      for (int i = 0; i < 8; i++) drive_bit(b[i], OS);
      drive_bit(par_v, OS);
      drive_bit(1'b1, OS);
   endtask

   task automatic test_parity();
      clear_mon();
      send_frame_par(8'h6E, 1'b1);
      idle(2 * OS);
      tests++;
      if (vcnt !== 1 || data_out !== 8'h6E || pcnt !== 0) begin
         fails++; $display("FAIL parity_good: got %0d/%h/%0d expected 1/6e/0", vcnt, data_out, pcnt);
      end
      clear_mon();
      send_frame_par(8'h6E, 1'b0);
      idle(2 * OS);
      tests++;
      if (pcnt !== 1 || vcnt !== 0) begin
         fails++; $display("FAIL parity_bad: got perr=%0d valid=%0d expected 1/0", pcnt, vcnt);
      end
   endtask
`endif

   initial begin
      rst_n      = 1'b1;
      rx         = 1'b1;
      enable_clk = 1'b1;
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch();
      test_frame_err();
      test_reset_mid();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      tests++;
      if (both !== 0) begin
         fails++; $display("FAIL pulse_overlap: got %0d expected 0", both);
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/uart_rx_byte.md
Name: uart_rx_byte

Overview:
- Oversampled UART receiver; deserialises the asynchronous `rx` line into bytes.
- Sits directly upstream of the LED command decoder: `data_out`/`data_valid` feed its byte input.
- Sample timing is taken from a single-cycle `enable_clk` tick at OVERSAMPLE x baud. No internal baud generator.
- Format is 8N1 by default: LSB first, one start bit, one stop bit.

Parameters:
- OVERSAMPLE, 16: `enable_clk` ticks per bit period. Must be an even number, >= 4.
- DATA_BITS, 8: data bits per frame, range 5..8. `data_out` is zero-extended to 8 bits.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous reset, active-high (1 = reset), despite the name
- enable_clk  input  1  oversample tick, one clk cycle wide
- rx  input  1  serial line, idle high, asynchronous to clk
- data_out  output  8  last correctly received byte, held until the next good frame
- data_valid  output  1  one-clk pulse, `data_out` updated in the same cycle
- frame_err  output  1  one-clk pulse, stop bit sampled low

Behaviour:
- Reset values:
  - `data_out` = 0x00, `data_valid` = 0, `frame_err` = 0.
  - State = IDLE, counters = 0, synchroniser flops = 1.
  - Reset asserted mid-frame aborts the frame with no pulse. The receiver resumes in IDLE and needs a fresh falling edge.
- Input synchronisation: `rx` passes through a 2-flop synchroniser (`rx_s`). All decisions use `rx_s`.
- Tick gating: state, tick counter and bit counter advance only on cycles with `enable_clk` = 1, except the IDLE edge detect.
- Tick counter width is clog2(OVERSAMPLE).
- IDLE:
  - On a clk where the previous `rx_s` = 1 and the current `rx_s` = 0, go to START with tick_cnt = 0.
  - Edge detection runs every clk and does not wait for a tick.
- START:
  - Count ticks.
  - When tick_cnt reaches OVERSAMPLE/2-1, sample `rx_s`. This is the mid-start-bit point.
  - Sample 1: false start/glitch. Return to IDLE with no pulse.
  - Sample 0: go to DATA with tick_cnt = 0 and bit_cnt = 0.
- DATA:
  - Every OVERSAMPLE ticks (tick_cnt = OVERSAMPLE-1), shift `rx_s` into the shift register at the MSB and shift right. The result is LSB-first assembly.
  - Increment bit_cnt and reset tick_cnt.
  - After DATA_BITS samples, go to STOP.
- STOP:
  - At tick_cnt = OVERSAMPLE-1, sample `rx_s`.
  - Sample 1: load `data_out` with the shift register and pulse `data_valid` for one clk.
  - Sample 0: pulse `frame_err` for one clk; `data_out` is unchanged.
  - Both cases return to IDLE.
  - A held-low line (break) therefore gives one `frame_err`, then waits in IDLE for a high-to-low edge.
- Latency: the pulse is registered and appears on the clk edge after the stop-bit sample tick. That is about 9.5 bit periods after the start edge for 8N1.
- `data_valid` and `frame_err` are never both high in the same cycle.
- Continuous `enable_clk` (tick every clk) is legal. Bit period = OVERSAMPLE clks.
- Back-to-back frames: a start bit immediately after the stop sample is detected. The sample point is mid-stop, so half a bit of margin remains.

Optional Feature:
- Macro: `UART_RX_PARITY_EN`
- Defined:
  - Adds a PARITY state between DATA and STOP. The frame becomes 8E1.
  - Parity is sampled at tick_cnt = OVERSAMPLE-1.
  - Adds output `parity_err` (1 bit, reset 0): one-clk pulse, asserted in place of `data_valid` when the XOR of the data bits and the parity bit is 1. `data_out` is not updated.
  - If the stop bit is low, `frame_err` takes priority and `parity_err` is not pulsed.
- Not defined: no PARITY state and no `parity_err` port. The frame is 8N1 as above.

Test Plan:
- Idle and tick every clk: send 0x6E as 8N1 (OVERSAMPLE = 16) -> exactly one `data_valid` pulse, `data_out` = 0x6E, `frame_err` never high.
- Back-to-back 0x35, 0xA0, 0xFF with no idle gap -> three `data_valid` pulses with those values in order.
- Start-bit glitch: `rx` low for 5 ticks, then high -> no pulse, state returns to IDLE. A following valid 0x01 is received correctly.
- Stop bit forced low while sending 0x55 -> one `frame_err` pulse, no `data_valid`, `data_out` retains its previous value. After `rx` returns high, 0x33 is received.
- Reset asserted during bit 4 of 0xC3 -> outputs go to 0 immediately. After release, a full 0x7E frame is received with `data_out` = 0x7E.
- With `UART_RX_PARITY_EN`: 0x6E with parity 1 -> `data_valid`, `data_out` = 0x6E. 0x6E with parity 0 -> `parity_err` pulse, no `data_valid`.
